// File: rtl/apb_target_fifo.sv
// rtl/apb_target_fifo.sv - APB target exposing an 8 x 32-bit receive FIFO with blocking reads
//
// Ports:
//   clk, clk__enable, reset_n        clock, clock enable (state holds when low), async active-low reset
//   apb_request__psel/penable/paddr/pwrite/pwdata   APB request; paddr is a word index, [1:0] decoded
//   apb_response__prdata/pready/perr                APB response, combinational from state + request
//   push_valid, push_data, push_ready               peripheral-side stream filling the FIFO
//   irq                                             level interrupt, fill level >= threshold
//
// Register map (paddr[1:0]): 0 DATA, 1 STATUS, 2 THRESHOLD, 3 CONTROL.

module apb_target_fifo (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        apb_request__psel,
    input  logic        apb_request__penable,
    input  logic [31:0] apb_request__paddr,
    input  logic        apb_request__pwrite,
    input  logic [31:0] apb_request__pwdata,
    output logic [31:0] apb_response__prdata,
    output logic        apb_response__pready,
    output logic        apb_response__perr,
    input  logic        push_valid,
    input  logic [31:0] push_data,
    output logic        push_ready,
    output logic        irq
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [3:0]  thresh_q, thresh_d;
    logic        block_q, block_d;
    logic [7:0]  timeout_q, timeout_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] fifo_mem [8];

    logic        access;
    logic        full;
    logic        empty;
    logic        apb_data_wr;
    logic        stream_push;
    logic        apb_push;
    logic        pop;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        unused_bits;

    assign unused_bits = ^{apb_request__paddr[31:2], apb_request__pwdata[31:16],
                           apb_request__pwdata[7:4]};

    assign access      = apb_request__psel & apb_request__penable;
    assign full        = (count_q == 4'd8);
    assign empty       = (count_q == 4'd0);
    assign apb_data_wr = access & apb_request__pwrite & (apb_request__paddr[1:0] == 2'd0);

    // The stream yields to a CPU loopback write so the FIFO has a single writer per cycle.
    assign push_ready  = !full & !apb_data_wr;
    assign stream_push = push_valid & push_ready;
    assign wr_en       = stream_push | apb_push;
    assign wr_data     = stream_push ? push_data : apb_request__pwdata;

    assign irq = (thresh_q != 4'd0) & (count_q >= thresh_q);

    always_comb begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        thresh_d   = thresh_q;
        block_d    = block_q;
        timeout_d  = timeout_q;
        apb_push   = 1'b0;
        pop        = 1'b0;
        apb_response__prdata = 32'd0;
        apb_response__pready = 1'b1;
        apb_response__perr   = 1'b0;

        if (access) begin
            if (apb_request__pwrite) begin
                case (apb_request__paddr[1:0])
                    2'd0: begin
                        if (full) ovf_d = 1'b1;
                        else      apb_push = 1'b1;
                    end
                    2'd1: begin
                        if (apb_request__pwdata[2]) ovf_d = 1'b0;
                        if (apb_request__pwdata[3]) unf_d = 1'b0;
                    end
                    2'd2: thresh_d = apb_request__pwdata[3:0];
                    2'd3: begin
                        block_d   = apb_request__pwdata[0];
                        timeout_d = apb_request__pwdata[15:8];
                    end
                endcase
            end else begin
                case (apb_request__paddr[1:0])
                    2'd0: begin
                        if (!empty) begin
                            apb_response__prdata = fifo_mem[rd_ptr_q];
                            pop = 1'b1;
                        end else if (state_q == ST_WAIT) begin
                            // wait_cnt_q is the number of stalled access cycles so far.
                            if (timeout_q != 8'd0 && wait_cnt_q == timeout_q) begin
                                apb_response__perr = 1'b1;
                                unf_d = 1'b1;
                            end else begin
                                apb_response__pready = 1'b0;
                                state_d    = ST_WAIT;
                                wait_cnt_d = wait_cnt_q + 8'd1;
                            end
                        end else if (block_q) begin
                            apb_response__pready = 1'b0;
                            state_d    = ST_WAIT;
                            wait_cnt_d = 8'd1;
                        end else begin
                            unf_d = 1'b1;
                        end
                    end
                    2'd1: apb_response__prdata = {20'd0, count_q, 4'd0, unf_q, ovf_q, full, empty};
                    2'd2: apb_response__prdata = {28'd0, thresh_q};
                    2'd3: apb_response__prdata = {16'd0, timeout_q, 7'd0, block_q};
                endcase
            end
        end

        wr_ptr_d = wr_ptr_q + {2'd0, wr_en};
        rd_ptr_d = rd_ptr_q + {2'd0, pop};
        count_d  = count_q + {3'd0, wr_en} - {3'd0, pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= 3'd0;
            wr_ptr_q   <= 3'd0;
            count_q    <= 4'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            thresh_q   <= 4'd0;
            block_q    <= 1'b0;
            timeout_q  <= 8'd0;
            wait_cnt_q <= 8'd0;
        end else if (clk__enable) begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            thresh_q   <= thresh_d;
            block_q    <= block_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once the pointers cover them.
    always_ff @(posedge clk) begin
        if (clk__enable && wr_en) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_apb_target_fifo.sv
// tb/tb_apb_target_fifo.sv - directed self-checking bench for apb_target_fifo

module tb_apb_target_fifo;

    logic        clk;
    logic        clk__enable;
    logic        reset_n;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    apb_target_fifo dut (
        .clk                  (clk),
        .clk__enable          (clk__enable),
        .reset_n              (reset_n),
        .apb_request__psel    (psel),
        .apb_request__penable (penable),
        .apb_request__paddr   (paddr),
        .apb_request__pwrite  (pwrite),
        .apb_request__pwdata  (pwdata),
        .apb_response__prdata (prdata),
        .apb_response__pready (pready),
        .apb_response__perr   (perr),
        .push_valid           (push_valid),
        .push_data            (push_data),
        .push_ready           (push_ready),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic stream_push(input logic [31:0] d);
        @(posedge clk); #1;
        push_valid = 1'b1;
        push_data  = d;
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d,
                            output logic e, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        waits = 0;
        while (!pready && waits < 50) begin
            @(posedge clk); #2;
            waits++;
        end
        check("rd_done", {31'd0, pready}, 32'd1);
        d = prdata;
        e = perr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          w;

    initial begin
        reset_n = 1'b0; clk__enable = 1'b1;
        psel = 1'b0; penable = 1'b0; paddr = 32'd0; pwrite = 1'b0; pwdata = 32'd0;
        push_valid = 1'b0; push_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready", {31'd0, pready}, 32'd1);
        check("rst_perr", {31'd0, perr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_push_ready", {31'd0, push_ready}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;

        // Stream in three words, drain them with zero wait states.
        stream_push(32'h11);
        stream_push(32'h22);
        stream_push(32'h33);
        apb_read(32'd0, rd, er, w); check("rd1", rd, 32'h11); check("rd1_waits", w, 0);
        apb_read(32'd0, rd, er, w); check("rd2", rd, 32'h22); check("rd2_waits", w, 0);
        apb_read(32'd0, rd, er, w); check("rd3", rd, 32'h33); check("rd3_perr", {31'd0, er}, 32'd0);
        apb_read(32'd1, rd, er, w); check("status_empty", rd, 32'h001);

        // Non-blocking read of an empty FIFO sets underflow.
        apb_read(32'd0, rd, er, w); check("unf_data", rd, 32'd0); check("unf_waits", w, 0);
        apb_read(32'd1, rd, er, w); check("status_unf", rd, 32'h009);
        apb_write(32'd1, 32'h8);
        apb_read(32'd1, rd, er, w); check("status_unf_clr", rd, 32'h001);

        // Fill, overflow via loopback write, clear, drain across the pointer wrap.
        for (int i = 0; i < 8; i++) stream_push(32'h100 + i);
        check("full_push_ready", {31'd0, push_ready}, 32'd0);
        apb_read(32'd1, rd, er, w); check("status_full", rd, 32'h802);
        apb_write(32'd0, 32'hDEAD);
        apb_read(32'd1, rd, er, w); check("status_ovf", rd, 32'h806);
        apb_write(32'd1, 32'h4);
        apb_read(32'd1, rd, er, w); check("status_ovf_clr", rd, 32'h802);
        for (int i = 0; i < 8; i++) begin
            apb_read(32'd0, rd, er, w);
            check("drain", rd, 32'h100 + i);
        end
        apb_read(32'd1, rd, er, w); check("status_drained", rd, 32'h001);
        apb_write(32'h4, 32'h1234);
        apb_read(32'h8, rd, er, w); check("loopback", rd, 32'h1234);

        // Blocking read, wait forever; data arrives later.
        apb_write(32'd3, 32'h1);
        fork
            apb_read(32'd0, rd, er, w);
            begin
                repeat (5) @(posedge clk);
                #1; push_valid = 1'b1; push_data = 32'hCAFE;
                @(posedge clk); #1; push_valid = 1'b0;
            end
        join
        check("blk_data", rd, 32'hCAFE);
        check("blk_perr", {31'd0, er}, 32'd0);
        check("blk_waits", w, 4);

        // Blocking read with timeout 4.
        apb_write(32'd3, 32'h0401);
        apb_read(32'd0, rd, er, w);
        check("to_waits", w, 4);
        check("to_perr", {31'd0, er}, 32'd1);
        check("to_data", rd, 32'd0);
        apb_read(32'd1, rd, er, w); check("to_status", rd, 32'h009);
        apb_read(32'd3, rd, er, w); check("control_rb", rd, 32'h0401);
        apb_write(32'd1, 32'h8);

        // Threshold interrupt.
        apb_write(32'd2, 32'h3);
        apb_read(32'd2, rd, er, w); check("thresh_rb", rd, 32'h3);
        stream_push(32'hA1);
        stream_push(32'hA2);
        check("irq_below", {31'd0, irq}, 32'd0);
        stream_push(32'hA3);
        check("irq_at", {31'd0, irq}, 32'd1);
        apb_read(32'd0, rd, er, w); check("irq_pop_data", rd, 32'hA1);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        apb_read(32'd0, rd, er, w); check("irq_drain2", rd, 32'hA2);
        apb_read(32'd0, rd, er, w); check("irq_drain3", rd, 32'hA3);

        // Clock enable low: a stream push must not land.
        clk__enable = 1'b0;
        stream_push(32'h55);
        clk__enable = 1'b1;
        apb_read(32'd1, rd, er, w); check("cken_hold", rd, 32'h001);

        // Reset during a blocking wait.
        apb_write(32'd3, 32'h1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1; check("rst_wait_stall", {31'd0, pready}, 32'd0);
        repeat (3) @(posedge clk);
        #1; check("rst_wait_still", {31'd0, pready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_pready", {31'd0, pready}, 32'd1);
        check("rst_mid_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        reset_n = 1'b1;
        apb_read(32'd1, rd, er, w); check("rst_status", rd, 32'h001);
        apb_read(32'd3, rd, er, w); check("rst_control", rd, 32'd0);
        apb_read(32'd2, rd, er, w); check("rst_thresh", rd, 32'd0);
        apb_read(32'd0, rd, er, w); check("rst_data", rd, 32'd0); check("rst_data_waits", w, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
